// File: rtl/dual_port_banked_sram_if.sv
// Bus bundle for the two requesters of dual_port_banked_sram.
// Handshake: a port's request is accepted in a cycle when x_req=1 and x_ack=1 in that cycle. A stalled requester holds req/we/addr/wdata stable until ack. Reads return x_rvalid=1 with x_rdata exactly one cycle after the accepting cycle.
interface dual_port_banked_sram_if #(
  parameter int ADDR_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_wdata;
  logic              a_ack;
  logic              a_rvalid;
  logic [7:0]        a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_wdata;
  logic              b_ack;
  logic              b_rvalid;
  logic [7:0]        b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rvalid, b_rdata
  );
endinterface

// File: rtl/dual_port_banked_sram.sv
// Multi-bank byte RAM shared by a CPU port (A) and a video port (B); ports hitting
// different banks proceed together, same-bank collisions go through an arbiter.
module spram32k8 (
  input  logic        clk,
  input  logic        i_we,
  input  logic [14:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);
  logic [7:0] r_mem [32768];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

module dual_port_banked_sram #(
  parameter int NUM_BANKS   = 2,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_port_banked_sram_if.slave  bus,
  output logic                    o_dbg_last_winner
);
  localparam int ADDR_W = 15 + $clog2(NUM_BANKS);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic {WIN_A = 1'b0, WIN_B = 1'b1} winner_t;

  winner_t           r_last_winner;
  logic [BANK_W-1:0] w_a_bank, w_b_bank;
  logic [BANK_W-1:0] r_a_rbank, r_b_rbank;
  logic              r_a_rvalid, r_b_rvalid;
  logic              w_conflict, w_a_wins, w_a_gnt, w_b_gnt;
  logic [7:0]        w_bank_rdata [NUM_BANKS];

  if (NUM_BANKS > 1) begin : g_bank_idx
    assign w_a_bank = bus.a_addr[ADDR_W-1:15];
    assign w_b_bank = bus.b_addr[ADDR_W-1:15];
  end else begin : g_one_bank
    assign w_a_bank = '0;
    assign w_b_bank = '0;
  end

  // Grants are gated by rst_n so nothing is acked or written while reset is held.
  assign w_conflict = bus.a_req & bus.b_req & (w_a_bank == w_b_bank);
  assign w_a_wins   = !ROUND_ROBIN || (r_last_winner == WIN_B);
  assign w_a_gnt    = rst_n & bus.a_req & (!w_conflict | w_a_wins);
  assign w_b_gnt    = rst_n & bus.b_req & (!w_conflict | !w_a_wins);

  assign bus.a_ack  = w_a_gnt;
  assign bus.b_ack  = w_b_gnt;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic        w_sel_a, w_sel_b, w_we;
    logic [14:0] w_addr, r_addr;
    logic [7:0]  w_wdata;

    assign w_sel_a = w_a_gnt && (w_a_bank == BANK_W'(gi));
    assign w_sel_b = w_b_gnt && (w_b_bank == BANK_W'(gi));

    // An idle bank keeps presenting its last address.
    always_comb begin
      w_addr  = r_addr;
      w_wdata = 8'h00;
      w_we    = 1'b0;
      if (w_sel_a) begin
        w_addr  = bus.a_addr[14:0];
        w_wdata = bus.a_wdata;
        w_we    = bus.a_we;
      end else if (w_sel_b) begin
        w_addr  = bus.b_addr[14:0];
        w_wdata = bus.b_wdata;
        w_we    = bus.b_we;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_addr <= '0;
      else        r_addr <= w_addr;
    end

    spram32k8 u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_bank_rdata[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid    <= 1'b0;
      r_b_rvalid    <= 1'b0;
      r_a_rbank     <= '0;
      r_b_rbank     <= '0;
      r_last_winner <= WIN_B;
    end else begin
      r_a_rvalid <= w_a_gnt & ~bus.a_we;
      r_b_rvalid <= w_b_gnt & ~bus.b_we;
      if (w_a_gnt & ~bus.a_we) r_a_rbank <= w_a_bank;
      if (w_b_gnt & ~bus.b_we) r_b_rbank <= w_b_bank;
      if (w_conflict) r_last_winner <= w_a_gnt ? WIN_A : WIN_B;
    end
  end

  assign bus.a_rvalid      = r_a_rvalid;
  assign bus.b_rvalid      = r_b_rvalid;
  assign bus.a_rdata       = w_bank_rdata[r_a_rbank];
  assign bus.b_rdata       = w_bank_rdata[r_b_rbank];
  assign o_dbg_last_winner = r_last_winner;
endmodule

// File: tb/tb_dual_port_banked_sram.sv
// Bench for dual_port_banked_sram: three configurations driven through one shared
// stimulus bus, checked against an address-map model with expected-read queues.
module tb_dual_port_banked_sram;
  logic clk;
  logic rst_n;
  int   sel;

  logic        a_req, a_we, b_req, b_we;
  logic [16:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;

  logic        dut_a_ack, dut_a_rvalid, dut_b_ack, dut_b_rvalid;
  logic [7:0]  dut_a_rdata, dut_b_rdata;
  logic        dbg0, dbg1, dbg2;

  int n_vec;
  int n_mis;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dual_port_banked_sram_if #(.ADDR_W(16)) bus0 ();
  dual_port_banked_sram_if #(.ADDR_W(16)) bus1 ();
  dual_port_banked_sram_if #(.ADDR_W(17)) bus2 ();

  dual_port_banked_sram #(.NUM_BANKS(2), .ROUND_ROBIN(1'b0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .o_dbg_last_winner(dbg0));
  dual_port_banked_sram #(.NUM_BANKS(2), .ROUND_ROBIN(1'b1)) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .o_dbg_last_winner(dbg1));
  dual_port_banked_sram #(.NUM_BANKS(4), .ROUND_ROBIN(1'b0)) u_dut_4b (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .o_dbg_last_winner(dbg2));

  assign bus0.a_req = a_req && (sel == 0);
  assign bus0.a_we = a_we;
  assign bus0.a_addr = a_addr[15:0];
  assign bus0.a_wdata = a_wdata;
  assign bus0.b_req = b_req && (sel == 0);
  assign bus0.b_we = b_we;
  assign bus0.b_addr = b_addr[15:0];
  assign bus0.b_wdata = b_wdata;

  assign bus1.a_req = a_req && (sel == 1);
  assign bus1.a_we = a_we;
  assign bus1.a_addr = a_addr[15:0];
  assign bus1.a_wdata = a_wdata;
  assign bus1.b_req = b_req && (sel == 1);
  assign bus1.b_we = b_we;
  assign bus1.b_addr = b_addr[15:0];
  assign bus1.b_wdata = b_wdata;

  assign bus2.a_req = a_req && (sel == 2);
  assign bus2.a_we = a_we;
  assign bus2.a_addr = a_addr;
  assign bus2.a_wdata = a_wdata;
  assign bus2.b_req = b_req && (sel == 2);
  assign bus2.b_we = b_we;
  assign bus2.b_addr = b_addr;
  assign bus2.b_wdata = b_wdata;

  always_comb begin
    dut_a_ack = bus0.a_ack;  dut_a_rvalid = bus0.a_rvalid;  dut_a_rdata = bus0.a_rdata;
    dut_b_ack = bus0.b_ack;  dut_b_rvalid = bus0.b_rvalid;  dut_b_rdata = bus0.b_rdata;
    if (sel == 1) begin
      dut_a_ack = bus1.a_ack;  dut_a_rvalid = bus1.a_rvalid;  dut_a_rdata = bus1.a_rdata;
      dut_b_ack = bus1.b_ack;  dut_b_rvalid = bus1.b_rvalid;  dut_b_rdata = bus1.b_rdata;
    end else if (sel == 2) begin
      dut_a_ack = bus2.a_ack;  dut_a_rvalid = bus2.a_rvalid;  dut_a_rdata = bus2.a_rdata;
      dut_b_ack = bus2.b_ack;  dut_b_rvalid = bus2.b_rvalid;  dut_b_rdata = bus2.b_rdata;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [int];
  bit         ref_last_b [3];
  logic [8:0] exp_a_q [$];
  logic [8:0] exp_b_q [$];
  logic       last_ga, last_gb;
  logic       obs_a_ack, obs_b_ack, obs_a_rvalid, obs_b_rvalid;
  logic [7:0] obs_a_rdata, obs_b_rdata;

  function automatic int bank_of(input logic [16:0] addr);
    return (sel == 2) ? int'(addr[16:15]) : int'(addr[15]);
  endfunction

  function automatic int key_of(input logic [16:0] addr);
    return sel * 32'h20000 + ((sel == 2) ? int'(addr) : int'(addr[15:0]));
  endfunction

  function automatic logic [8:0] lookup(input logic [16:0] addr);
    int k;
    k = key_of(addr);
    if (ref_mem.exists(k)) return {1'b1, ref_mem[k]};
    return 9'h000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (config %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  task automatic check_read(input string port, input logic rv, input logic [7:0] rd,
                            inout logic [8:0] q [$]);
    logic [8:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({port, "_rvalid"}, rv, 1'b1);
      if (e[8]) check({port, "_rdata"}, rd, e[7:0]);
    end else begin
      check({port, "_rvalid"}, rv, 1'b0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set just after a rising edge; this samples at the falling edge,
  // scores the cycle, advances the model and returns just after the next rising edge.
  task automatic step();
    logic conflict, a_wins, ga, gb;
    @(negedge clk);
    conflict = a_req && b_req && (bank_of(a_addr) == bank_of(b_addr));
    a_wins   = (sel != 1) || ref_last_b[sel];
    ga       = a_req && (!conflict || a_wins);
    gb       = b_req && (!conflict || !a_wins);
    obs_a_ack = dut_a_ack;  obs_a_rvalid = dut_a_rvalid;  obs_a_rdata = dut_a_rdata;
    obs_b_ack = dut_b_ack;  obs_b_rvalid = dut_b_rvalid;  obs_b_rdata = dut_b_rdata;
    check("a_ack", dut_a_ack, ga);
    check("b_ack", dut_b_ack, gb);
    check_read("a", dut_a_rvalid, dut_a_rdata, exp_a_q);
    check_read("b", dut_b_rvalid, dut_b_rdata, exp_b_q);
    if (ga && !a_we) exp_a_q.push_back(lookup(a_addr));
    if (gb && !b_we) exp_b_q.push_back(lookup(b_addr));
    if (ga && a_we) ref_mem[key_of(a_addr)] = a_wdata;
    if (gb && b_we) ref_mem[key_of(b_addr)] = b_wdata;
    if (conflict) ref_last_b[sel] = !ga;
    last_ga = ga;
    last_gb = gb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic drain();
    idle();
    step();
  endtask

  function automatic logic [16:0] rand_addr();
    logic [16:0] bank;
    logic [16:0] low;
    bank = 17'($urandom_range(0, (sel == 2) ? 3 : 1));
    low  = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 7)) : 17'(15'h7FF8 + $urandom_range(0, 7));
    return (bank << 15) | low;
  endfunction

  // A stalled request is held unchanged until it is acked.
  task automatic rand_cycle();
    if (!(a_req && !last_ga)) begin
      a_req = ($urandom_range(0, 3) != 0);
      a_we = 1'($urandom_range(0, 1));
      a_addr = rand_addr();
      a_wdata = 8'($urandom_range(0, 255));
    end
    if (!(b_req && !last_gb)) begin
      b_req = ($urandom_range(0, 3) != 0);
      b_we = 1'($urandom_range(0, 1));
      b_addr = rand_addr();
      b_wdata = 8'($urandom_range(0, 255));
    end
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [8:0] e;
    n_vec = 0;
    n_mis = 0;
    sel = 0;
    rst_n = 1'b0;
    last_ga = 1'b0;
    last_gb = 1'b0;
    idle();
    ref_last_b = '{1'b1, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_a_rvalid", dut_a_rvalid, 1'b0);
      check("reset_b_rvalid", dut_b_rvalid, 1'b0);
    end
    sel = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Concurrent writes to different banks, then crossed reads.
    a_req = 1; a_we = 1; a_addr = 17'h00010; a_wdata = 8'h5A;
    b_req = 1; b_we = 1; b_addr = 17'h08010; b_wdata = 8'hA5;
    step();
    check("dual_write_acks", {obs_a_ack, obs_b_ack}, 2'b11);
    a_we = 0; a_addr = 17'h08010;
    b_we = 0; b_addr = 17'h00010;
    step();
    drain();
    check("cross_read_rvalid", {obs_a_rvalid, obs_b_rvalid}, 2'b11);
    check("cross_read_a_rdata", obs_a_rdata, 8'hA5);
    check("cross_read_b_rdata", obs_b_rdata, 8'h5A);

    // Fixed priority: B starves while A keeps hitting the same bank.
    a_req = 1; a_we = 0; a_addr = 17'h00010;
    b_req = 1; b_we = 0; b_addr = 17'h00100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fp_a_ack", obs_a_ack, 1'b1);
      check("fp_b_stall", obs_b_ack, 1'b0);
    end
    a_req = 0;
    step();
    check("fp_b_ack_after_a_drop", obs_b_ack, 1'b1);
    drain();

    // Read-after-write on one port.
    a_req = 1; a_we = 1; a_addr = 17'h00123; a_wdata = 8'h3C;
    step();
    a_we = 0;
    step();
    drain();
    check("raw_rvalid", obs_a_rvalid, 1'b1);
    check("raw_rdata", obs_a_rdata, 8'h3C);

    // Asynchronous reset one cycle after a read ack; requests during reset are ignored.
    a_req = 1; a_we = 0; a_addr = 17'h00010;
    step();
    idle();
    e = exp_a_q.pop_front();
    check("prereset_rvalid", dut_a_rvalid, 1'b1);
    check("prereset_rdata", dut_a_rdata, e[7:0]);
    #2;
    rst_n = 1'b0;
    a_req = 1; a_we = 1; a_addr = 17'h00010; a_wdata = 8'hEE;
    b_req = 1; b_we = 1; b_addr = 17'h08010; b_wdata = 8'h11;
    #1;
    check("reset_async_rvalid", dut_a_rvalid, 1'b0);
    check("reset_a_ack", dut_a_ack, 1'b0);
    check("reset_b_ack", dut_b_ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_rvalid", {dut_a_rvalid, dut_b_rvalid}, 2'b00);
      check("reset_hold_acks", {dut_a_ack, dut_b_ack}, 2'b00);
    end
    @(posedge clk);
    #1;
    idle();
    exp_a_q.delete();
    exp_b_q.delete();
    ref_last_b = '{1'b1, 1'b1, 1'b1};
    rst_n = 1'b1;
    a_req = 1; a_we = 0; a_addr = 17'h00010;
    b_req = 1; b_we = 0; b_addr = 17'h08010;
    step();
    check("post_reset_acks", {obs_a_ack, obs_b_ack}, 2'b11);
    drain();
    check("post_reset_a_rdata", obs_a_rdata, 8'h5A);
    check("post_reset_b_rdata", obs_b_rdata, 8'hA5);

    // Round robin under continuous conflict.
    sel = 1;
    a_req = 1; a_we = 0; a_addr = 17'h00020;
    b_req = 1; b_we = 0; b_addr = 17'h00040;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_a_ack", obs_a_ack, 1'((i % 2) == 0));
      check("rr_b_ack", obs_b_ack, 1'((i % 2) == 1));
    end
    drain();

    // Four banks: unique byte at both ends of every bank, read back via B.
    sel = 2;
    for (int bk = 0; bk < 4; bk++) begin
      for (int j = 0; j < 2; j++) begin
        a_req = 1; a_we = 1;
        a_addr = 17'(bk << 15) | ((j == 0) ? 17'h07FFF : 17'h00000);
        a_wdata = ((j == 0) ? 8'hFF : 8'h00) ^ 8'(bk);
        step();
      end
    end
    idle();
    for (int bk = 0; bk < 4; bk++) begin
      for (int j = 0; j < 2; j++) begin
        b_req = 1; b_we = 0;
        b_addr = 17'(bk << 15) | ((j == 0) ? 17'h07FFF : 17'h00000);
        step();
      end
    end
    b_addr = 17'h0FFFF;
    step();
    b_addr = 17'h10000;
    step();
    check("alias_0ffff", obs_b_rdata, 8'hFE);
    drain();
    check("alias_10000", obs_b_rdata, 8'h02);

    // Randomized traffic on each configuration.
    for (int s = 0; s < 3; s++) begin
      drain();
      sel = s;
      idle();
      last_ga = 1'b0;
      last_gb = 1'b0;
      repeat (400) rand_cycle();
    end
    drain();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
